// File: rtl/input_debouncer_pkg.sv
// Shared types and helpers for input_debouncer.
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } debounce_state_e;

    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_sync.sv
// sync_rst_synchronizer: STAGES-deep flop chain with synchronous active-high reset.
module sync_rst_synchronizer #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a 1-bit input into a clean level with rise/fall pulses.
// Optional glitch counter enabled by INPUT_DEBOUNCER_GLITCH_CNT_EN.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          ASYNC         = 1'b1,
    parameter bit          RESET_VAL     = 1'b0,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                d_i,
    output logic                q_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                busy_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int unsigned     CW          = cnt_width(STABLE_CYCLES);
    localparam int unsigned     SYNC_STAGES = ASYNC ? 2 : 1;
    localparam logic [CW-1:0]   LP_LAST     = CW'(STABLE_CYCLES);
    localparam debounce_state_e LP_RST_ST   = RESET_VAL ? STABLE_HI : STABLE_LO;

    logic            w_sync;
    debounce_state_e r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_q;
    logic            r_rise;
    logic            r_fall;

    sync_rst_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .d_i    (d_i),
        .q_o    (w_sync)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= LP_RST_ST;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_sync) begin
                        r_state <= CHECK_HI;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                CHECK_HI: begin
                    if (!w_sync) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= STABLE_HI;
                        r_q     <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_sync) begin
                        r_state <= CHECK_LO;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                CHECK_LO: begin
                    if (w_sync) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= STABLE_LO;
                        r_q     <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= LP_RST_ST;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign q_o    = r_q;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign busy_o = (r_state == CHECK_HI) || (r_state == CHECK_LO);

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch_cnt;
    logic                w_abort;

    // An abort is a CHECK state seeing the synchronized input fall back.
    assign w_abort = ((r_state == CHECK_HI) && !w_sync) ||
                     ((r_state == CHECK_LO) &&  w_sync);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign glitch_cnt_o = r_glitch_cnt;
`else
    assign glitch_cnt_o = '0;
`endif

endmodule
